// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module : dcache_pkg
// Brief  : Shared types for the data-cache dirty-bit tracker.
// Rev    : 1.0
// ============================================================================
package dcache_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      OFFER = 2'd2,
      DONE  = 2'd3
   } flush_state_e;

endpackage
`default_nettype wire

// File: rtl/dirty_flush_walker.sv
`default_nettype none
// ============================================================================
// Module : dirty_flush_walker
// Brief  : Flush FSM walking every (set,way) and offering dirty lines for write-back.
// Rev    : 1.0
// ============================================================================
module dirty_flush_walker
   import dcache_pkg::*;
#(
   parameter int NUM_SETS = 8,
   parameter int NUM_WAYS = 2,
   parameter int IDX_W    = $clog2(NUM_SETS),
   parameter int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_req,
   input  logic             wb_ready,
   input  logic             cur_dirty,
   output logic             flush_busy,
   output logic             flush_done,
   output logic             wb_valid,
   output logic [IDX_W-1:0] wb_index,
   output logic [WAY_W-1:0] wb_way,
   output logic             wb_fire
);

   localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_SETS - 1);
   localparam logic [WAY_W-1:0] c_last_way = WAY_W'(NUM_WAYS - 1);

   flush_state_e     r_state;
   logic [IDX_W-1:0] r_idx;
   logic [WAY_W-1:0] r_way;
   logic             r_busy;
   logic             r_done;
   logic             r_valid;
   logic             w_last;
   logic [IDX_W-1:0] w_next_idx;
   logic [WAY_W-1:0] w_next_way;

   // Way advances fastest; the set steps when the way wraps.
   always_comb begin
      w_last     = (r_idx == c_last_idx) && (r_way == c_last_way);
      w_next_way = (r_way == c_last_way) ? '0 : r_way + 1'b1;
      w_next_idx = (r_way == c_last_way) ? r_idx + 1'b1 : r_idx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_way   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (flush_req) begin
                  r_state <= SCAN;
                  r_idx   <= '0;
                  r_way   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            SCAN: begin
               if (cur_dirty) begin
                  r_state <= OFFER;
                  r_valid <= 1'b1;
               end else if (w_last) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_idx <= w_next_idx;
                  r_way <= w_next_way;
               end
            end
            OFFER: begin
               if (wb_ready) begin
                  r_valid <= 1'b0;
                  if (w_last) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= SCAN;
                     r_idx   <= w_next_idx;
                     r_way   <= w_next_way;
                  end
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign flush_busy = r_busy;
   assign flush_done = r_done;
   assign wb_valid   = r_valid;
   assign wb_index   = r_idx;
   assign wb_way     = r_way;
   assign wb_fire    = r_valid && wb_ready;

endmodule
`default_nettype wire

// File: rtl/dirty_tracker.sv
`default_nettype none
// ============================================================================
// Module : dirty_tracker
// Brief  : Per-set/per-way dirty-bit array with running count and flush walker.
// Rev    : 1.0
// ============================================================================
module dirty_tracker
   import dcache_pkg::*;
#(
   parameter int NUM_SETS = 8,
   parameter int NUM_WAYS = 2,
   parameter int IDX_W    = $clog2(NUM_SETS),
   parameter int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
   parameter int CNT_W    = $clog2(NUM_SETS * NUM_WAYS + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [IDX_W-1:0]    rd_index,
   output logic [NUM_WAYS-1:0] rd_dirty,
   input  logic                wr_en,
   input  logic [IDX_W-1:0]    wr_index,
   input  logic [WAY_W-1:0]    wr_way,
   input  logic                wr_dirty,
   input  logic                flush_req,
   output logic                flush_busy,
   output logic                flush_done,
   output logic                wb_valid,
   output logic [IDX_W-1:0]    wb_index,
   output logic [WAY_W-1:0]    wb_way,
   input  logic                wb_ready,
   output logic [CNT_W-1:0]    dirty_count
);

   logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
   logic [CNT_W-1:0]    r_count;
   logic                w_fire;
   logic                w_wr_old;
   logic                w_clr_old;
   logic                w_same;
   logic                w_wr_up;
   logic                w_wr_dn;
   logic                w_clr_dn;

   dirty_flush_walker #(
      .NUM_SETS (NUM_SETS),
      .NUM_WAYS (NUM_WAYS),
      .IDX_W    (IDX_W),
      .WAY_W    (WAY_W)
   ) u_walker (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush_req  (flush_req),
      .wb_ready   (wb_ready),
      .cur_dirty  (w_clr_old),
      .flush_busy (flush_busy),
      .flush_done (flush_done),
      .wb_valid   (wb_valid),
      .wb_index   (wb_index),
      .wb_way     (wb_way),
      .wb_fire    (w_fire)
   );

   // A write to the entry being cleared by the handshake overrides the clear.
   always_comb begin
      w_wr_old  = dirty_q[wr_index][wr_way];
      w_clr_old = dirty_q[wb_index][wb_way];
      w_same    = (wr_index == wb_index) && (wr_way == wb_way);
      w_wr_up   = wr_en && wr_dirty && !w_wr_old;
      w_wr_dn   = wr_en && !wr_dirty && w_wr_old;
      w_clr_dn  = w_fire && w_clr_old && !(wr_en && w_same);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            dirty_q[s] <= '0;
         end
         r_count <= '0;
      end else begin
         if (w_fire) begin
            dirty_q[wb_index][wb_way] <= 1'b0;
         end
         if (wr_en) begin
            dirty_q[wr_index][wr_way] <= wr_dirty;
         end
         r_count <= r_count + CNT_W'(w_wr_up) - CNT_W'(w_wr_dn) - CNT_W'(w_clr_dn);
      end
   end

   assign rd_dirty    = dirty_q[rd_index];
   assign dirty_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_dirty_tracker.sv
`default_nettype none
// ============================================================================
// Module : tb_dirty_tracker
// Brief  : Directed self-checking bench for dirty_tracker with write-back scoreboard.
// Rev    : 1.0
// ============================================================================
module tb_dirty_tracker;

   logic       clk;
   logic       rst_n;
   logic [2:0] rd_index;
   logic [1:0] rd_dirty;
   logic       wr_en;
   logic [2:0] wr_index;
   logic [0:0] wr_way;
   logic       wr_dirty;
   logic       flush_req;
   logic       flush_busy;
   logic       flush_done;
   logic       wb_valid;
   logic [2:0] wb_index;
   logic [0:0] wb_way;
   logic       wb_ready;
   logic [4:0] dirty_count;

   int         total;
   int         bad;
   logic [1:0] mdl [8];
   logic [3:0] exp_q [$];

   dirty_tracker u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rd_index    (rd_index),
      .rd_dirty    (rd_dirty),
      .wr_en       (wr_en),
      .wr_index    (wr_index),
      .wr_way      (wr_way),
      .wr_dirty    (wr_dirty),
      .flush_req   (flush_req),
      .flush_busy  (flush_busy),
      .flush_done  (flush_done),
      .wb_valid    (wb_valid),
      .wb_index    (wb_index),
      .wb_way      (wb_way),
      .wb_ready    (wb_ready),
      .dirty_count (dirty_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int mdl_count();
      int n = 0;
      for (int s = 0; s < 8; s++) n += int'(mdl[s][0]) + int'(mdl[s][1]);
      return n;
   endfunction

   task automatic do_write(input int idx, input int way, input logic val);
      wr_en    = 1'b1;
      wr_index = 3'(idx);
      wr_way   = 1'(way);
      wr_dirty = val;
      tick();
      wr_en = 1'b0;
      mdl[idx][way] = val;
   endtask

   task automatic check_array(input string tag);
      for (int s = 0; s < 8; s++) begin
         rd_index = 3'(s);
         #0;
         chk(tag, 32'(rd_dirty), 32'(mdl[s]));
      end
   endtask

   // Run a whole flush with wb_ready held high; checks offers against the queue.
   task automatic run_flush(input int exp_busy, input int exp_offers);
      int  busy_cyc = 0;
      int  dones    = 0;
      int  offers   = 0;
      bit  finished = 0;
      logic [3:0] e;
      wb_ready  = 1'b1;
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      for (int c = 0; c < 60 && !finished; c++) begin
         if (flush_busy) busy_cyc++;
         if (flush_done) begin
            dones++;
            finished = 1;
         end
         if (wb_valid && wb_ready) begin
            offers++;
            chk("wb_queue_has_entry", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("wb_entry", 32'({wb_index, wb_way}), 32'(e));
               mdl[e[3:1]][e[0]] = 1'b0;
            end
         end
         tick();
      end
      chk("flush_finished", 32'(finished), 32'd1);
      chk("flush_busy_cycles", 32'(busy_cyc), 32'(exp_busy));
      chk("flush_done_pulses", 32'(dones), 32'd1);
      chk("flush_offers", 32'(offers), 32'(exp_offers));
      chk("flush_idle_after", 32'(flush_busy), 32'd0);
      chk("flush_done_low_after", 32'(flush_done), 32'd0);
   endtask

   task automatic wait_valid(input string tag);
      bit seen = 0;
      for (int c = 0; c < 40 && !seen; c++) begin
         if (wb_valid) seen = 1;
         else tick();
      end
      chk(tag, 32'(seen), 32'd1);
   endtask

   initial begin
      logic [3:0] e;
      total     = 0;
      bad       = 0;
      rst_n     = 1'b0;
      rd_index  = '0;
      wr_en     = 1'b0;
      wr_index  = '0;
      wr_way    = '0;
      wr_dirty  = 1'b0;
      flush_req = 1'b0;
      wb_ready  = 1'b0;
      for (int s = 0; s < 8; s++) mdl[s] = 2'b00;
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Reset after random writes
      for (int k = 0; k < 6; k++) do_write(int'($urandom_range(7)), int'($urandom_range(1)), 1'b1);
      #2 rst_n = 1'b0;
      #1;
      for (int s = 0; s < 8; s++) mdl[s] = 2'b00;
      check_array("reset_rd_dirty");
      chk("reset_count", 32'(dirty_count), 32'd0);
      chk("reset_wb_valid", 32'(wb_valid), 32'd0);
      chk("reset_busy", 32'(flush_busy), 32'd0);
      chk("reset_done", 32'(flush_done), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // Write then read back
      do_write(3, 1, 1'b1);
      rd_index = 3'd3;
      #0;
      chk("wr_rd_3", 32'(rd_dirty), 32'h2);
      chk("wr_count_1", 32'(dirty_count), 32'd1);
      do_write(5, 0, 1'b1);
      chk("wr_count_2", 32'(dirty_count), 32'd2);
      do_write(5, 0, 1'b0);
      chk("wr_count_clear", 32'(dirty_count), 32'd1);
      do_write(0, 0, 1'b1);
      do_write(7, 0, 1'b1);
      check_array("wr_array");
      chk("wr_count_3", 32'(dirty_count), 32'(mdl_count()));

      // Full flush of three dirty lines
      exp_q.push_back({3'd0, 1'b0});
      exp_q.push_back({3'd3, 1'b1});
      exp_q.push_back({3'd7, 1'b0});
      run_flush(20, 3);
      chk("flush1_queue_empty", 32'(exp_q.size()), 32'd0);
      check_array("flush1_array");
      chk("flush1_count", 32'(dirty_count), 32'd0);

      // Backpressure then write/handshake collision
      do_write(3, 1, 1'b1);
      do_write(6, 0, 1'b1);
      exp_q.push_back({3'd3, 1'b1});
      exp_q.push_back({3'd6, 1'b0});
      wb_ready  = 1'b0;
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      wait_valid("bp_offer_seen");
      e = exp_q.pop_front();
      for (int c = 0; c < 5; c++) begin
         chk("bp_valid_held", 32'(wb_valid), 32'd1);
         chk("bp_entry_held", 32'({wb_index, wb_way}), 32'(e));
         tick();
      end
      wb_ready = 1'b1;
      wr_en    = 1'b1;
      wr_index = 3'd3;
      wr_way   = 1'b1;
      wr_dirty = 1'b1;
      tick();
      wr_en    = 1'b0;
      wb_ready = 1'b0;
      rd_index = 3'd3;
      #0;
      chk("collide_bit_kept", 32'(rd_dirty), 32'h2);
      chk("collide_count", 32'(dirty_count), 32'd2);

      // Reset while the second line is offered
      wait_valid("second_offer_seen");
      e = exp_q.pop_front();
      chk("second_offer_entry", 32'({wb_index, wb_way}), 32'(e));
      #2 rst_n = 1'b0;
      #1;
      for (int s = 0; s < 8; s++) mdl[s] = 2'b00;
      chk("midrst_wb_valid", 32'(wb_valid), 32'd0);
      chk("midrst_busy", 32'(flush_busy), 32'd0);
      chk("midrst_count", 32'(dirty_count), 32'd0);
      check_array("midrst_array");
      tick();
      rst_n = 1'b1;
      tick();
      chk("midrst_stays_idle", 32'(flush_busy | wb_valid), 32'd0);

      // Flush of an empty array: scan only, then done
      run_flush(17, 0);
      chk("empty_count", 32'(dirty_count), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
